// File: rtl/eth_rx_frame_parser.sv
// Purpose: parse one received Ethernet frame (dest MAC .. FCS), filter on dest MAC,
//          extract ethertype, forward payload with FCS stripped, check CRC32/length.
// Latency: payload byte out 1 cycle after the inclk that pushes it out of a 4-byte delay
//          line; hdr_valid 1 cycle after byte 13; out_done 1 cycle after in_done.
// Backpressure: none; inclk may assert every cycle and outputs are strobes.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   my_mac                 station address (frame byte 0 = my_mac[47:40])
//   inclk, in, in_done     byte strobe, byte, end-of-frame pulse
//   outclk, out            payload byte strobe and byte
//   hdr_valid, ethertype   header-latched pulse, big-endian ethertype
//   out_done, out_ok       per-frame verdict pulse and qualifier
//   good_cnt, bad_cnt      saturating verdict counters
module eth_rx_frame_parser #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] my_mac,
  input  logic        inclk,
  input  logic [7:0]  in,
  input  logic        in_done,
  output logic        outclk,
  output logic [7:0]  out,
  output logic        hdr_valid,
  output logic [15:0] ethertype,
  output logic        out_done,
  output logic        out_ok,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DROP, ST_VERDICT} state_t;

  state_t          state;
  logic [31:0]     crc;
  logic [10:0]     cnt;        // bytes received so far in this frame
  logic            mac_hit;    // dest bytes so far match my_mac
  logic            bc_hit;     // dest bytes so far are all 0xFF
  logic [7:0]      eth_hi;
  logic [3:0][7:0] dl;         // payload delay line, dl[3] oldest
  logic [2:0]      fill;

  logic            start;
  logic            drop_now;
  logic            mac_m;
  logic            bc_m;
  logic            verdict_ok;
  logic [31:0]     crc_n;
  logic [10:0]     cnt_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    case (i)
      3'd0:    return m[47:40];
      3'd1:    return m[39:32];
      3'd2:    return m[31:24];
      3'd3:    return m[23:16];
      3'd4:    return m[15:8];
      3'd5:    return m[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Next CRC/count include a byte arriving with in_done, so the verdict sees it.
  always_comb begin
    start = inclk && (state == ST_IDLE || state == ST_VERDICT);
    crc_n = crc;
    cnt_n = cnt;
    if (inclk) begin
      crc_n = crc_byte(start ? 32'hFFFF_FFFF : crc, in);
      if (start)               cnt_n = 11'd1;
      else if (cnt != 11'h7FF) cnt_n = cnt + 11'd1;
    end
    mac_m      = mac_hit && (in == mac_byte(my_mac, cnt[2:0]));
    bc_m       = bc_hit && (in == 8'hFF);
    drop_now   = (state == ST_HEADER) && inclk && (cnt == 11'd5) && !mac_m && !bc_m;
    verdict_ok = (crc_n == RESIDUE) && (cnt_n >= MIN_LEN) && (cnt_n <= MAX_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      crc       <= 32'hFFFF_FFFF;
      cnt       <= '0;
      mac_hit   <= 1'b0;
      bc_hit    <= 1'b0;
      eth_hi    <= '0;
      dl        <= '0;
      fill      <= '0;
      outclk    <= 1'b0;
      out       <= '0;
      hdr_valid <= 1'b0;
      ethertype <= '0;
      out_done  <= 1'b0;
      out_ok    <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      outclk    <= 1'b0;
      hdr_valid <= 1'b0;
      out_done  <= 1'b0;
      crc       <= crc_n;
      cnt       <= cnt_n;

      case (state)
        // VERDICT is the out_done cycle; a byte here starts the next frame.
        ST_IDLE, ST_VERDICT: begin
          if (inclk) begin
            state   <= ST_HEADER;
            mac_hit <= (in == my_mac[47:40]);
            bc_hit  <= (in == 8'hFF);
            dl      <= '0;
            fill    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (inclk) begin
            if (cnt < 11'd6) begin
              mac_hit <= mac_m;
              bc_hit  <= bc_m;
            end
            if (drop_now) state <= ST_DROP;
            if (cnt == 11'd12) eth_hi <= in;
            if (cnt == 11'd13) begin
              ethertype <= {eth_hi, in};
              hdr_valid <= 1'b1;
              state     <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (inclk) begin
            dl <= {dl[2:0], in};
            if (fill == 3'd4) begin
              if (cnt_n <= MAX_LEN) begin
                outclk <= 1'b1;
                out    <= dl[3];
              end
            end else begin
              fill <= fill + 3'd1;
            end
          end
        end
        ST_DROP: begin
          if (in_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A frame rejected on its last dest byte gets no verdict even if in_done coincides.
      if (in_done && (state == ST_HEADER || state == ST_PAYLOAD) && !drop_now) begin
        out_done <= 1'b1;
        out_ok   <= verdict_ok;
        if (verdict_ok) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
        state <= ST_VERDICT;
      end
    end
  end

endmodule

// File: doc/eth_rx_frame_parser.md
Name: eth_rx_frame_parser

Overview:
- Receive-path stage directly downstream of dibits_to_bytes. It consumes the byte stream of one Ethernet frame, starting at the first destination-MAC byte after the SFD and ending with the last FCS byte.
- Filters frames on destination MAC, extracts the ethertype, and forwards payload bytes with the 4-byte FCS stripped.
- Checks the CRC32 and the frame length, then reports a per-frame good/bad verdict and keeps good/bad frame counters.

Parameters:
MIN_FRAME_LEN, 64, minimum legal total length in bytes, header+payload+FCS; never below 18
MAX_FRAME_LEN, 1518, maximum legal total length in bytes

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous, active-high reset
my_mac  input  48  station address, byte 0 of the frame = my_mac[47:40]
inclk  input  1  one-cycle strobe: in holds a valid byte
in  input  8  received byte
in_done  input  1  one-cycle pulse: end of frame; may coincide with the final inclk
outclk  output  1  one-cycle strobe: out holds a payload byte
out  output  8  payload byte
hdr_valid  output  1  one-cycle pulse once ethertype is latched (accepted frames only)
ethertype  output  16  bytes 12,13 of the frame, big-endian; holds until the next frame
out_done  output  1  one-cycle pulse: verdict for an accepted frame
out_ok  output  1  qualifies out_done: CRC good and length legal; holds until the next out_done
good_cnt  output  16  saturating count of accepted frames with out_ok=1
bad_cnt  output  16  saturating count of accepted frames with out_ok=0

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0xFFFFFFFF, byte count 0, counters 0. Reset mid-frame aborts the frame with no out_done; the next inclk starts a new frame.
- Byte index: an 11-bit counter counts bytes of the current frame and saturates at 2047.
- CRC: reflected CRC32, polynomial 0xEDB88320, initial value 0xFFFFFFFF. It is updated one byte per inclk, LSB first, over every byte including the FCS. The CRC is good iff the register equals the residue 0xDEBB20E3 after the last byte.
- States:
  - IDLE: the first inclk enters HEADER as byte 0.
  - HEADER, bytes 0-13:
    - Bytes 0-5 are compared against my_mac and against FF:FF:FF:FF:FF:FF.
    - At byte 5, if neither matches, go to DROP.
    - Bytes 12-13 are latched into ethertype; hdr_valid pulses the cycle after byte 13. Then go to PAYLOAD.
  - PAYLOAD: payload bytes enter a 4-byte delay line.
    - An incoming byte that finds the line full causes the oldest byte to be emitted: outclk and out are asserted one cycle after that inclk.
    - The last 4 bytes, the FCS, are therefore never emitted.
    - Once the byte count exceeds MAX_FRAME_LEN, forwarding stops; CRC and count continue.
  - DROP: bytes are consumed silently with no outputs of any kind; in_done returns to IDLE and no counter changes.
  - VERDICT, entered on in_done from HEADER or PAYLOAD:
    - out_done pulses the cycle after in_done, or after the final inclk if they coincide.
    - out_ok = CRC good AND MIN_FRAME_LEN ≤ length ≤ MAX_FRAME_LEN.
    - Exactly one of good_cnt/bad_cnt increments in that same cycle, saturating at 0xFFFF. Then go to IDLE.
- in_done in HEADER before byte 13 gives out_ok=0 and bad_cnt+1, with no hdr_valid.
- in_done in IDLE is ignored.
- The delay line is cleared at every frame start.
- Payload bytes are forwarded before the verdict is known; downstream must discard the frame when out_ok=0.
- Simultaneous inclk and in_done: the byte is fully processed (CRC, count, emit) before the verdict is taken.
- Back-to-back frames: an inclk in the same cycle as out_done is taken as byte 0 of the next frame.
- Throughput: inclk may assert every cycle.

Test Plan:
1. Good unicast frame, 64 bytes total: dest = my_mac = 02:00:00:00:00:01, ethertype 0x0800, 46 payload bytes 0x00..0x2D, FCS computed by the bench model.
   - hdr_valid with ethertype=0x0800.
   - Exactly 46 outclk with out=0x00..0x2D in order.
   - out_done with out_ok=1; good_cnt=1.
2. Same frame with payload byte 10 flipped to 0xFF:
   - 46 bytes forwarded.
   - out_ok=0; bad_cnt=1; good_cnt unchanged.
3. Broadcast frame, then a frame to 02:00:00:00:00:99:
   - The broadcast frame is accepted with out_ok=1.
   - The second frame produces no outclk, hdr_valid or out_done, and neither counter changes.
4. Valid-CRC 40-byte frame (runt):
   - 22 payload bytes forwarded.
   - out_ok=0; bad_cnt+1.
5. in_done coincident with the final FCS inclk, followed by the next frame's byte 0 in the out_done cycle:
   - Correct verdict for frame 1.
   - Frame 2 is parsed fully and correctly.
6. rst asserted at byte 20 of a good frame, then a complete good frame is sent:
   - Outputs and counters are 0 after reset, with no out_done for the aborted frame.
   - The second frame gives good_cnt=1.
